// File: rtl/branch_resolve_unit_pkg.sv
// bru_pkg: shared types and constants for the branch resolve unit.
// Struct fields are sized for the widest supported parameterisation
// (tag up to 32 bits, target up to 64 bits); narrower instances zero-extend.
package bru_pkg;

  localparam int BRU_PC_W      = 32;
  localparam int BRU_TAG_MAX_W = 32;
  localparam int BRU_BTA_MAX_W = 64;

  // Distance from a branch to its sequential successor.
  localparam logic [BRU_PC_W-1:0] BRU_FT_OFFSET = 32'd4;

  typedef enum logic {
    UPD_INSERT = 1'b0,
    UPD_INVAL  = 1'b1
  } upd_kind_t;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_t;

  typedef struct packed {
    logic                     valid;
    logic [BRU_PC_W-1:0]      pc;
    logic                     hit;
    logic [BRU_BTA_MAX_W-1:0] bta;
  } bru_track_t;

  typedef struct packed {
    upd_kind_t                kind;
    logic [BRU_TAG_MAX_W-1:0] tag;
    logic [BRU_BTA_MAX_W-1:0] bta;
  } bru_upd_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// BTB update bus: valid/ready channel carrying insert/invalidate requests.
// master = branch resolve unit (producer), slave = BTB (consumer).
interface branch_resolve_unit_if
  import bru_pkg::*;
#(
  parameter int W_PC  = 8,
  parameter int W_BTA = 32
);

  logic             upd_valid;
  logic             upd_ready;
  upd_kind_t        upd_kind;
  logic [W_PC-1:0]  upd_tag;
  logic [W_BTA-1:0] upd_bta;

  modport master (
    output upd_valid,
    input  upd_ready,
    output upd_kind,
    output upd_tag,
    output upd_bta
  );

  modport slave (
    input  upd_valid,
    output upd_ready,
    input  upd_kind,
    input  upd_tag,
    input  upd_bta
  );

endinterface

// File: rtl/branch_resolve_unit_upd_fifo.sv
// bru_upd_fifo: valid/ready FIFO for BTB update requests. A push that
// arrives while full with no simultaneous pop is dropped and flagged.
// DEPTH must be a power of two (pointers wrap by natural overflow).
module bru_upd_fifo
  import bru_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = bru_upd_t
) (
  input  logic clk,
  input  logic reset,
  input  logic push_i,
  input  T     data_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o,
  output logic drop_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  T              mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  occ_t          occ;
  logic          pop;
  logic          push_ok;

  // Occupancy classification and push/pop decisions.
  always_comb begin
    occ = OCC_PARTIAL;
    if (cnt_q == '0) begin
      occ = OCC_EMPTY;
    end else if (cnt_q == CW'(DEPTH)) begin
      occ = OCC_FULL;
    end
    valid_o = (occ != OCC_EMPTY);
    pop     = valid_o && ready_i;
    push_ok = push_i && ((occ != OCC_FULL) || pop);
    drop_o  = push_i && (occ == OCC_FULL) && !pop;
    // Idle outputs read as zero so the bus is quiet when nothing is queued.
    data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  end

  // Next-state for pointers and occupancy counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    unique case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state; reset empties the queue and discards pending entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage; contents are only meaningful behind the counter.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: carries BTB predictions from F through D to E,
// compares them with the resolved branch outcome, issues a one-cycle PC
// redirect on a misprediction and queues a BTB insert/invalidate request.
// Optional feature: define BRU_STATS_EN to add saturating 32-bit counters
// br_cnt, mispred_cnt and drop_cnt.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int W_PC    = 8,
  parameter int W_BTA   = 32,
  parameter int Q_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       pc_f,
  input  logic              hit_f,
  input  logic [W_BTA-1:0]  bta_f,
  input  logic              stall_d,
  input  logic              flush_d,
  input  logic              flush_e,
  input  logic              branch_e,
  input  logic              taken_e,
  input  logic [W_BTA-1:0]  target_e,
  output logic              redirect_e,
  output logic [W_BTA-1:0]  redirect_pc,
  branch_resolve_unit_if.master upd
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]       br_cnt,
  output logic [31:0]       mispred_cnt,
  output logic [31:0]       drop_cnt
`endif
);

  bru_track_t dtrk_q, dtrk_d;
  bru_track_t etrk_q, etrk_d;
  bru_upd_t   upd_entry;
  bru_upd_t   head;
  logic       upd_push;
  logic       upd_drop;
  logic       fifo_valid;
  logic [W_BTA-1:0] ft_pc;

  // D tracking register: flush/reset clear valid and hit; stall holds.
  always_comb begin
    dtrk_d = dtrk_q;
    if (reset || flush_d) begin
      dtrk_d.valid = 1'b0;
      dtrk_d.hit   = 1'b0;
    end else if (!stall_d) begin
      dtrk_d.valid = 1'b1;
      dtrk_d.pc    = pc_f;
      dtrk_d.hit   = hit_f;
      dtrk_d.bta   = BRU_BTA_MAX_W'(bta_f);
    end
  end

  // E tracking register: follows D every cycle unless flushed.
  always_comb begin
    etrk_d = dtrk_q;
    if (reset || flush_e) begin
      etrk_d.valid = 1'b0;
      etrk_d.hit   = 1'b0;
    end
  end

  // ---- F/D and D/E stage boundaries ----
  always_ff @(posedge clk) begin
    dtrk_q <= dtrk_d;
    etrk_q <= etrk_d;
  end

  // E-stage classification: redirect and BTB update request.
  always_comb begin
    ft_pc       = W_BTA'(etrk_q.pc + BRU_FT_OFFSET);
    redirect_e  = 1'b0;
    redirect_pc = '0;
    upd_push    = 1'b0;
    upd_entry   = '0;
    upd_entry.tag = BRU_TAG_MAX_W'(etrk_q.pc[W_PC-1:0]);
    if (etrk_q.valid) begin
      if (branch_e) begin
        if (taken_e && (!etrk_q.hit || (W_BTA'(etrk_q.bta) != target_e))) begin
          // Unpredicted or wrong-target taken branch: (re)install target.
          redirect_e     = 1'b1;
          redirect_pc    = target_e;
          upd_push       = 1'b1;
          upd_entry.kind = UPD_INSERT;
          upd_entry.bta  = BRU_BTA_MAX_W'(target_e);
        end else if (!taken_e && etrk_q.hit) begin
          redirect_e     = 1'b1;
          redirect_pc    = ft_pc;
          upd_push       = 1'b1;
          upd_entry.kind = UPD_INVAL;
        end
      end else if (etrk_q.hit) begin
        // BTB aliased a non-branch: fall through and evict the entry.
        redirect_e     = 1'b1;
        redirect_pc    = ft_pc;
        upd_push       = 1'b1;
        upd_entry.kind = UPD_INVAL;
      end
    end
  end

  bru_upd_fifo #(
    .DEPTH (Q_DEPTH),
    .T     (bru_upd_t)
  ) u_upd_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (upd_push),
    .data_i  (upd_entry),
    .valid_o (fifo_valid),
    .ready_i (upd.upd_ready),
    .data_o  (head),
    .drop_o  (upd_drop)
  );

  // Narrow the package-wide entry onto the parameterised bus.
  always_comb begin
    upd.upd_valid = fifo_valid;
    upd.upd_kind  = head.kind;
    upd.upd_tag   = W_PC'(head.tag);
    upd.upd_bta   = W_BTA'(head.bta);
  end

  // Upper bits of the package-wide fields are zero for narrow instances.
  logic unused_hi;
  assign unused_hi = ^{etrk_q.bta, head.tag, head.bta};

`ifdef BRU_STATS_EN
  logic [31:0] br_cnt_q, mispred_cnt_q, drop_cnt_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      if (etrk_q.valid && branch_e) br_cnt_q      <= sat_inc(br_cnt_q);
      if (redirect_e)               mispred_cnt_q <= sat_inc(mispred_cnt_q);
      if (upd_drop)                 drop_cnt_q    <= sat_inc(drop_cnt_q);
    end
  end

  assign br_cnt      = br_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
  assign drop_cnt    = drop_cnt_q;
`else
  logic unused_drop;
  assign unused_drop = upd_drop;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a scoreboard of expected BTB
// updates. Honours BRU_STATS_EN when it is defined for the build.
module tb_branch_resolve_unit;
  import bru_pkg::*;

  localparam int QD = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_f;
  logic        hit_f;
  logic [31:0] bta_f;
  logic        stall_d, flush_d, flush_e;
  logic        branch_e, taken_e;
  logic [31:0] target_e;
  logic        redirect_e;
  logic [31:0] redirect_pc;
`ifdef BRU_STATS_EN
  logic [31:0] br_cnt, mispred_cnt, drop_cnt;
`endif

  branch_resolve_unit_if #(.W_PC(8), .W_BTA(32)) upd_bus ();

  branch_resolve_unit #(.W_PC(8), .W_BTA(32), .Q_DEPTH(QD)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_f        (pc_f),
    .hit_f       (hit_f),
    .bta_f       (bta_f),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .flush_e     (flush_e),
    .branch_e    (branch_e),
    .taken_e     (taken_e),
    .target_e    (target_e),
    .redirect_e  (redirect_e),
    .redirect_pc (redirect_pc),
    .upd         (upd_bus.master)
`ifdef BRU_STATS_EN
    ,
    .br_cnt      (br_cnt),
    .mispred_cnt (mispred_cnt),
    .drop_cnt    (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        kind;
    logic [7:0]  tag;
    logic [31:0] bta;
  } exp_t;

  exp_t sbq[$];
  int   nvec  = 0;
  int   nfail = 0;
  int   exp_mis  = 0;
  int   exp_drop = 0;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  task automatic fset(input logic [31:0] pc, input logic h, input logic [31:0] b);
    pc_f  = pc;
    hit_f = h;
    bta_f = b;
  endtask

  task automatic eset(input logic br, input logic tk, input logic [31:0] t);
    branch_e = br;
    taken_e  = tk;
    target_e = t;
  endtask

  // One clock: check outputs mid-cycle, update the model, advance past the edge.
  task automatic step(input string nm, input logic er, input logic [31:0] epc,
                      input logic ep, input logic ek, input logic [7:0] et,
                      input logic [31:0] eb);
    exp_t e;
    logic popped;
    @(negedge clk);
    chk({nm, "_redir"}, 64'(redirect_e), 64'(er));
    chk({nm, "_rpc"}, 64'(redirect_pc), 64'(epc));
    chk({nm, "_uvalid"}, 64'(upd_bus.upd_valid), 64'(sbq.size() != 0));
    if (sbq.size() != 0) begin
      chk({nm, "_ukind"}, 64'(upd_bus.upd_kind), 64'(sbq[0].kind));
      chk({nm, "_utag"}, 64'(upd_bus.upd_tag), 64'(sbq[0].tag));
      chk({nm, "_ubta"}, 64'(upd_bus.upd_bta), 64'(sbq[0].bta));
    end else begin
      chk({nm, "_uidle"}, 64'({upd_bus.upd_kind, upd_bus.upd_tag, upd_bus.upd_bta}), 64'd0);
    end
`ifdef BRU_STATS_EN
    chk({nm, "_miscnt"}, 64'(mispred_cnt), 64'(exp_mis));
    chk({nm, "_dropcnt"}, 64'(drop_cnt), 64'(exp_drop));
`endif
    popped = upd_bus.upd_ready && (sbq.size() != 0);
    if (popped) void'(sbq.pop_front());
    if (reset) begin
      sbq.delete();
      exp_mis  = 0;
      exp_drop = 0;
    end else begin
      if (er) exp_mis++;
      if (ep) begin
        if (sbq.size() < QD) begin
          e.kind = ek; e.tag = et; e.bta = eb;
          sbq.push_back(e);
        end else begin
          exp_drop++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string nm);
    step(nm, 1'b0, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    fset(32'h0, 1'b0, 32'h0);
    eset(1'b0, 1'b0, 32'h0);
    stall_d = 1'b0; flush_d = 1'b0; flush_e = 1'b0;
    upd_bus.upd_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
`ifdef BRU_STATS_EN
    chk("rst_brcnt", 64'(br_cnt), 64'd0);
`endif
    idle("rst");
    reset = 1'b0;

    // Correct prediction: hit, taken, matching target.
    fset(32'h10, 1'b1, 32'h40); idle("t1_f");
    fset(32'h0, 1'b0, 32'h0);   idle("t1_d");
    eset(1'b1, 1'b1, 32'h40);   idle("t1_e");
    eset(1'b0, 1'b0, 32'h0);    idle("t1_post");

    // Cold miss, taken.
    fset(32'h24, 1'b0, 32'h0);  idle("t2_f");
    fset(32'h0, 1'b0, 32'h0);   idle("t2_d");
    eset(1'b1, 1'b1, 32'h80);   step("t2_e", 1'b1, 32'h80, 1'b1, 1'b0, 8'h24, 32'h80);
    eset(1'b0, 1'b0, 32'h0);    idle("t2_pop"); idle("t2_empty");

    // Predicted taken, actually not taken.
    fset(32'h30, 1'b1, 32'h90); idle("t3_f");
    fset(32'h0, 1'b0, 32'h0);   idle("t3_d");
    eset(1'b1, 1'b0, 32'h55);   step("t3_e", 1'b1, 32'h34, 1'b1, 1'b1, 8'h30, 32'h0);
    eset(1'b0, 1'b0, 32'h0);    idle("t3_pop"); idle("t3_empty");

    // Backpressure: four back-to-back misses, third dropped, push+pop while full.
    upd_bus.upd_ready = 1'b0;
    fset(32'h50, 1'b0, 32'h0);  idle("t4_c1");
    fset(32'h54, 1'b0, 32'h0);  idle("t4_c2");
    fset(32'h58, 1'b0, 32'h0);  eset(1'b1, 1'b1, 32'hA00);
    step("t4_c3", 1'b1, 32'hA00, 1'b1, 1'b0, 8'h50, 32'hA00);
    fset(32'h5C, 1'b0, 32'h0);  eset(1'b1, 1'b1, 32'hA04);
    step("t4_c4", 1'b1, 32'hA04, 1'b1, 1'b0, 8'h54, 32'hA04);
    fset(32'h0, 1'b0, 32'h0);   eset(1'b1, 1'b1, 32'hA08);
    step("t4_c5", 1'b1, 32'hA08, 1'b1, 1'b0, 8'h58, 32'hA08);
    upd_bus.upd_ready = 1'b1;   eset(1'b1, 1'b1, 32'hA0C);
    step("t4_c6", 1'b1, 32'hA0C, 1'b1, 1'b0, 8'h5C, 32'hA0C);
    eset(1'b0, 1'b0, 32'h0);
    idle("t4_c7"); idle("t4_c8"); idle("t4_c9");
`ifdef BRU_STATS_EN
    chk("t4_drop1", 64'(drop_cnt), 64'd1);
`endif

    // BTB alias on a non-branch.
    fset(32'h64, 1'b1, 32'h70); idle("t5_f");
    fset(32'h0, 1'b0, 32'h0);   idle("t5_d");
    step("t5_e", 1'b1, 32'h68, 1'b1, 1'b1, 8'h64, 32'h0);
    idle("t5_pop"); idle("t5_empty");

    // flush_e removes an aliasing non-branch before it reaches E.
    fset(32'h60, 1'b1, 32'h70); idle("t6_f");
    fset(32'h0, 1'b0, 32'h0);   flush_e = 1'b1; idle("t6_d");
    flush_e = 1'b0;             idle("t6_e");

    // flush_d kills the prediction on its way into D.
    fset(32'h6C, 1'b1, 32'h70); flush_d = 1'b1; idle("t7_f");
    flush_d = 1'b0; fset(32'h0, 1'b0, 32'h0); idle("t7_d");
    idle("t7_e");

    // Stall D for three cycles with bubbles into E: one classification only.
    fset(32'h84, 1'b0, 32'h0);  idle("t8_f");
    stall_d = 1'b1; flush_e = 1'b1; fset(32'h99, 1'b1, 32'h11);
    idle("t8_s1");
    eset(1'b1, 1'b1, 32'hC0);
    idle("t8_s2"); idle("t8_s3");
    stall_d = 1'b0; flush_e = 1'b0; fset(32'h0, 1'b0, 32'h0);
    idle("t8_rel");
    step("t8_e", 1'b1, 32'hC0, 1'b1, 1'b0, 8'h84, 32'hC0);
    eset(1'b0, 1'b0, 32'h0);
    idle("t8_pop"); idle("t8_empty");

    // Reset with two queued entries.
    upd_bus.upd_ready = 1'b0;
    fset(32'hA0, 1'b0, 32'h0);  idle("t9_f1");
    fset(32'hA4, 1'b0, 32'h0);  idle("t9_f2");
    fset(32'h0, 1'b0, 32'h0);   eset(1'b1, 1'b1, 32'h1);
    step("t9_e1", 1'b1, 32'h1, 1'b1, 1'b0, 8'hA0, 32'h1);
    eset(1'b1, 1'b1, 32'h2);
    step("t9_e2", 1'b1, 32'h2, 1'b1, 1'b0, 8'hA4, 32'h2);
    eset(1'b0, 1'b0, 32'h0);    reset = 1'b1;
    idle("t9_rst");
    reset = 1'b0; upd_bus.upd_ready = 1'b1;
`ifdef BRU_STATS_EN
    chk("t9_brcnt0", 64'(br_cnt), 64'd0);
`endif
    idle("t9_post1"); idle("t9_post2");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Execute-stage counterpart to the fetch-side BTB. It carries each fetch-time prediction (hit, predicted target) down the F→D→E pipeline and compares it with the real branch outcome in Execute. On a wrong prediction it drives a one-cycle PC redirect to the hazard unit and queues a BTB write request (insert or invalidate) on a valid/ready interface. The BTB consumes those requests at its own pace.

## Interface
Parameters:
- W_PC, 8: tag width; low PC bits sent with each BTB update.
- W_BTA, 32: branch target address width.
- Q_DEPTH, 2: update queue depth; must be a power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- pc_f  in  32  fetch address of the instruction in F.
- hit_f, bta_f  in  1, W_BTA  BTB lookup result for pc_f.
- stall_d  in  1  hold the D tracking register.
- flush_d, flush_e  in  1  clear the D / E tracking register to "not predicted, invalid".
- branch_e  in  1  the instruction in E is a branch whose condition has been evaluated.
- taken_e  in  1  the branch in E is actually taken.
- target_e  in  W_BTA  actual target from the ALU.
- redirect_e  out  1  misprediction; fetch must restart at redirect_pc.
- redirect_pc  out  W_BTA  correct next fetch address.
- upd_valid  out  1  head of the update queue is valid.
- upd_ready  in  1  BTB accepts the head entry this cycle.
- upd_kind  out  1  0 = insert/overwrite, 1 = invalidate.
- upd_tag  out  W_PC  low bits of the branch PC.
- upd_bta  out  W_BTA  target to write; zero for invalidate.

## Operation
- Tracking registers hold {valid, pc, hit, bta}. F→D is captured when stall_d=0. D→E is captured every cycle. flush_d / flush_e take priority over capture and clear valid and hit.
- E-stage classification, evaluated only when the E register is valid. Fallthrough (FT) = pc_e+4.
  - branch, hit, taken, bta==target_e: correct; no action.
  - branch, hit, taken, bta!=target_e: redirect to target_e; push INSERT.
  - branch, hit, not taken: redirect to FT; push INVAL.
  - branch, no hit, taken: redirect to target_e; push INSERT.
  - branch, no hit, not taken: correct; no action.
  - not a branch, hit (alias): redirect to FT; push INVAL.
- Update queue is a FIFO with occupancy states EMPTY, PARTIAL, FULL. A pop happens when upd_valid && upd_ready.
  - Push and pop in the same cycle: both occur, including when FULL.
  - Push while FULL with no pop: the new update is dropped. Redirect is still issued, because BTB updates are hints only.
- Pointers wrap modulo Q_DEPTH. Occupancy is tracked with a counter of width log2(Q_DEPTH)+1.
- Reset, including reset asserted mid-operation: queue empty, all tracking registers invalid. A pending update is discarded and not replayed.

## Timing
- redirect_e and redirect_pc are combinational from the E tracking register and the E-stage inputs. They are valid in the same cycle the branch sits in E and last exactly one cycle per branch.
- Update latency: a pushed entry is visible on upd_valid on the cycle after classification.
- upd_* are stable while upd_valid=1 and upd_ready=0.
- Reset values: redirect_e=0, redirect_pc=0, upd_valid=0, upd_kind=0, upd_tag=0, upd_bta=0, stats counters 0.
- Ordering: updates leave the queue in program order.

## Configuration
- BRU_STATS_EN defined: adds outputs br_cnt, mispred_cnt and drop_cnt, each 32 bits and saturating at all-ones.
  - br_cnt counts classified branches.
  - mispred_cnt counts redirects.
  - drop_cnt counts updates dropped while FULL.
- BRU_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.

## Structure
- Package bru_pkg holds:
  - upd_kind_t (UPD_INSERT=0, UPD_INVAL=1);
  - bru_track_t struct {valid, pc, hit, bta};
  - bru_upd_t struct {kind, tag, bta};
  - the FT offset constant 4.
- Sub-module bru_upd_fifo: a parameterised valid/ready FIFO with a full-drop flag. Top-level holds the tracking pipeline and classification.

## Test plan
- Correct prediction: hit_f=1 and bta_f=0x40 at pc 0x10 reach E with taken_e=1, target_e=0x40 → no redirect, upd_valid stays 0.
- Cold miss taken: pc 0x24, hit=0, taken, target 0x80 → redirect_pc=0x80 that cycle; next cycle upd_valid=1, kind=0, tag=0x24, bta=0x80.
- Predicted taken but not taken: pc 0x30, hit, bta=0x90, taken_e=0 → redirect_pc=0x34, push INVAL with tag 0x30.
- Backpressure: upd_ready=0 while three mispredicts occur back-to-back (Q_DEPTH=2) → first two entries queued in order, third dropped (drop_cnt=1 if BRU_STATS_EN), all three redirect.
- Flush and stall: flush_e asserted on a hit non-branch → no redirect. stall_d held for 3 cycles → D prediction retained, one classification only.
- Reset with 2 queued entries → next cycle upd_valid=0 and the queue is empty.
